// File: rtl/demux_sched_pkg.sv
// Shared channel type, channel constants and helpers for the 4-way demux scheduler.
package demux_sched_pkg;

  typedef logic [1:0] chan_t;

  localparam chan_t CH_A = 2'd0;
  localparam chan_t CH_B = 2'd1;
  localparam chan_t CH_C = 2'd2;
  localparam chan_t CH_D = 2'd3;
  localparam int    NCH  = 4;

  function automatic chan_t next_chan(input chan_t c);
    return c + 2'd1;
  endfunction

endpackage

// File: rtl/demux_chan_slot.sv
// One-entry output slot: holds a word until its sink takes it, reads zero when empty.
module demux_chan_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  // A slot being drained this cycle can be reloaded in the same cycle.
  assign free = ~valid | ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= wdata;
    end else if (valid && ready) begin
      valid <= 1'b0;
      data  <= '0;
    end
  end

endmodule

// File: rtl/demux4_scheduler.sv
// Routes a valid/ready word stream to four one-entry channel slots, round-robin or addressed.
// Optional DEMUX_SKIP_BUSY_EN: round-robin skips a busy slot and takes the next free one.
import demux_sched_pkg::*;

module demux4_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       rr_ptr
);

  logic [NCH-1:0]   slot_free;
  logic [NCH-1:0]   slot_valid;
  logic [NCH-1:0]   load;
  logic [WIDTH-1:0] slot_data [NCH];
  chan_t            target;
  logic             accept;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    target = rr_ptr;
    if (mode) begin
      target = in_dest;
    end
`ifdef DEMUX_SKIP_BUSY_EN
    else if (!slot_free[rr_ptr]) begin
      // Scan downward so the nearest free slot after rr_ptr wins.
      for (int i = NCH - 1; i >= 1; i--) begin
        if (slot_free[chan_t'(rr_ptr + chan_t'(i))]) target = chan_t'(rr_ptr + chan_t'(i));
      end
    end
`endif
  end

  assign in_ready = rst_n & slot_free[target];
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    assign load[k] = accept & (target == chan_t'(k));

    demux_chan_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .wdata (in_data),
      .ready (out_ready[k]),
      .valid (slot_valid[k]),
      .data  (slot_data[k]),
      .free  (slot_free[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= CH_A;
    end else if (accept && !mode) begin
      rr_ptr <= next_chan(target);
    end
  end

  assign out_valid = slot_valid;
  assign out_a     = slot_data[CH_A];
  assign out_b     = slot_data[CH_B];
  assign out_c     = slot_data[CH_C];
  assign out_d     = slot_data[CH_D];

endmodule

// File: tb/tb_demux4_scheduler.sv
// Directed scoreboard bench for demux4_scheduler; expected words are queued per channel
// at issue time and a negedge monitor pops them whenever a channel hands a word to its sink.
module tb_demux4_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [3:0] in_data;
  logic [1:0] in_dest;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_a, out_b, out_c, out_d;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] rr_ptr;

  int tests = 0;
  int fails = 0;

  logic [3:0] sb [4][$];

`ifdef DEMUX_SKIP_BUSY_EN
  localparam logic [1:0] RR_T2 = 2'd3;
`else
  localparam logic [1:0] RR_T2 = 2'd2;
`endif

  demux4_scheduler #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] out_of(input int k);
    case (k)
      0:       return out_a;
      1:       return out_b;
      2:       return out_c;
      default: return out_d;
    endcase
  endfunction

  // Monitor: a word leaves channel k when out_valid[k] & out_ready[k] at the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (sb[k].size() == 0) begin
            check($sformatf("unexpected_word_ch%0d", k), {28'd0, out_of(k)}, 32'hFFFF_FFFF);
          end else begin
            check($sformatf("data_ch%0d", k), {28'd0, out_of(k)}, {28'd0, sb[k].pop_front()});
          end
        end else if (!out_valid[k]) begin
          check($sformatf("zero_empty_ch%0d", k), {28'd0, out_of(k)}, 32'd0);
        end
      end
    end
  end

  // Issue one word; inputs change at posedge+1, in_ready is judged at the negedge.
  task automatic send(input logic m, input logic [1:0] dest, input logic [3:0] d,
                      input int exp_ch, input logic exp_rdy, input logic [1:0] exp_rr);
    mode     = m;
    in_dest  = dest;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    check($sformatf("in_ready_w%0h", d), {31'd0, in_ready}, {31'd0, exp_rdy});
    if (exp_rdy) sb[exp_ch].push_back(d);
    @(posedge clk);
    #1;
    check($sformatf("rr_ptr_w%0h", d), {30'd0, rr_ptr}, {30'd0, exp_rr});
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    mode     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_data", {out_a, out_b, out_c, out_d}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 4; k++) sb[k].delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_rr_ptr", {30'd0, rr_ptr}, 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_data   = '0;
    in_dest   = '0;
    in_valid  = 1'b1;
    out_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_out_valid", {28'd0, out_valid}, 32'd0);
    check("reset_rr_ptr", {30'd0, rr_ptr}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    // 1: round-robin stream, all sinks ready.
    send(0, 0, 4'h1, 0, 1, 2'd1);
    send(0, 0, 4'h2, 1, 1, 2'd2);
    send(0, 0, 4'h3, 2, 1, 2'd3);
    send(0, 0, 4'h4, 3, 1, 2'd0);
    send(0, 0, 4'h5, 0, 1, 2'd1);
    idle(2);

    // 2: channel B stalled.
    do_reset();
    out_ready = 4'b1101;
    send(0, 0, 4'h6, 0, 1, 2'd1);
    send(0, 0, 4'h7, 1, 1, 2'd2);
    send(0, 0, 4'h8, 2, 1, 2'd3);
    send(0, 0, 4'h9, 3, 1, 2'd0);
    send(0, 0, 4'hA, 0, 1, 2'd1);
    check("b_held_valid", {31'd0, out_valid[1]}, 32'd1);
    check("b_held_data", {28'd0, out_b}, 32'h7);
`ifdef DEMUX_SKIP_BUSY_EN
    send(0, 0, 4'hB, 2, 1, 2'd3);
    out_ready = 4'hF;
`else
    send(0, 0, 4'hB, 1, 0, 2'd1);
    out_ready = 4'hF;
    send(0, 0, 4'hB, 1, 1, 2'd2);
`endif
    idle(2);

    // 3: addressed word held by a stalled sink D.
    out_ready = 4'b0111;
    send(1, 3, 4'h9, 3, 1, RR_T2);
    for (int i = 0; i < 3; i++) begin
      check("d_held_valid", {31'd0, out_valid[3]}, 32'd1);
      check("d_held_data", {28'd0, out_d}, 32'h9);
      send(1, 3, 4'h5, 3, 0, RR_T2);
    end
    in_valid  = 1'b0;
    out_ready = 4'hF;
    idle(2);

    // 4: drain and reload slot A in the same cycle.
    send(1, 0, 4'h3, 0, 1, RR_T2);
    send(1, 0, 4'hE, 0, 1, RR_T2);
    check("reload_valid_a", {31'd0, out_valid[0]}, 32'd1);
    check("reload_data_a", {28'd0, out_a}, 32'hE);
    idle(2);

    // 5: asynchronous reset with every slot full.
    out_ready = 4'h0;
    send(1, 0, 4'h1, 0, 1, RR_T2);
    send(1, 1, 4'h2, 1, 1, RR_T2);
    send(1, 2, 4'h3, 2, 1, RR_T2);
    send(1, 3, 4'h4, 3, 1, RR_T2);
    check("all_full", {28'd0, out_valid}, 32'hF);
    do_reset();
    out_ready = 4'hF;

    // 6: mode switches leave rr_ptr alone.
    send(0, 3, 4'h5, 0, 1, 2'd1);
    send(0, 3, 4'h6, 1, 1, 2'd2);
    send(1, 0, 4'h7, 0, 1, 2'd2);
    send(1, 3, 4'h8, 3, 1, 2'd2);
    send(0, 0, 4'h9, 2, 1, 2'd3);
    idle(3);

    for (int k = 0; k < 4; k++) begin
      check($sformatf("left_over_ch%0d", k), sb[k].size(), 32'd0);
    end
    check("final_out_valid", {28'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
